// File: rtl/seg7_scan_display.sv
// Scans an 8-digit common-anode 7-segment display. The upper four digits show x[15:0] and
// the lower four show y[15:0]; both values are snapshotted once per frame.
module seg7_scan_display #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLANK_LZ    = 0
) (
   input  logic        Clk,
   input  logic        rst,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [6:0]  out7,
   output logic [7:0]  en_out,
   output logic        frame_done
);

   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] TICK_VAL = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] prescaler;
   logic [2:0]    index;
   logic [15:0]   snap_x;
   logic [15:0]   snap_y;

   logic          tick_c;
   logic [15:0]   half_c;
   logic [3:0]    nibble_c;
   logic          lz_c;
   logic [6:0]    seg_c;

   // Only the low halves of the debug buses are displayed.
   logic unused_hi;
   assign unused_hi = ^{x[31:16], y[31:16]};

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Nibble select and leading-zero detection within the active half.
   always_comb begin
      tick_c   = (prescaler == TICK_VAL);
      half_c   = index[2] ? snap_x : snap_y;
      nibble_c = half_c[3:0];
      lz_c     = 1'b0;
      case (index[1:0])
         2'd0: begin
            nibble_c = half_c[3:0];
            lz_c     = 1'b0;
         end
         2'd1: begin
            nibble_c = half_c[7:4];
            lz_c     = (half_c[15:4] == '0);
         end
         2'd2: begin
            nibble_c = half_c[11:8];
            lz_c     = (half_c[15:8] == '0);
         end
         default: begin
            nibble_c = half_c[15:12];
            lz_c     = (half_c[15:12] == '0);
         end
      endcase
      seg_c = ((BLANK_LZ != 0) && lz_c) ? 7'h7F : hex7(nibble_c);
   end

   // Slot timing, frame snapshot and registered drive; anodes go dark for one cycle per digit change.
   always_ff @(posedge Clk) begin
      if (rst) begin
         prescaler  <= '0;
         index      <= 3'd0;
         snap_x     <= 16'h0000;
         snap_y     <= 16'h0000;
         out7       <= 7'h7F;
         en_out     <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         out7       <= seg_c;
         if (tick_c) begin
            prescaler <= '0;
            index     <= index + 3'd1;
            en_out    <= 8'hFF;
            if (index == 3'd7) begin
               snap_x     <= x[15:0];
               snap_y     <= y[15:0];
               frame_done <= 1'b1;
            end
         end else begin
            prescaler <= prescaler + PW'(1);
            en_out    <= ~(8'b1 << index);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: two instances (plain and leading-zero blanking)
// scanned in lockstep, with per-slot expectations queued ahead of the scan.
module tb_seg7_scan_display;

   localparam int unsigned DIV = 4;

   typedef struct {
      string      tag;
      logic [7:0] en;
      logic [6:0] seg_a;
      logic [6:0] seg_b;
   } slot_t;

   logic        Clk = 1'b0;
   logic        rst;
   logic [31:0] x, y, xb, yb;
   logic [6:0]  out7_a, out7_b;
   logic [7:0]  en_a, en_b;
   logic        fd_a, fd_b;

   slot_t sb_q[$];
   int checks   = 0;
   int errors   = 0;
   int cycle    = 0;
   int last_fd  = -1;
   int fd_count = 0;

   always #5 Clk = ~Clk;

   seg7_scan_display #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) dut_a (
      .Clk(Clk), .rst(rst), .x(x), .y(y),
      .out7(out7_a), .en_out(en_a), .frame_done(fd_a)
   );

   seg7_scan_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut_b (
      .Clk(Clk), .rst(rst), .x(xb), .y(yb),
      .out7(out7_b), .en_out(en_b), .frame_done(fd_b)
   );

   function automatic logic [6:0] hex_ref(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic logic [3:0] nib_of(input logic [15:0] hx, input logic [15:0] hy, input int d);
      logic [15:0] h;
      h = (d < 4) ? hy : hx;
      return 4'(h >> (4 * (d % 4)));
   endfunction

   function automatic logic lz_ref(input logic [15:0] hx, input logic [15:0] hy, input int d);
      logic [15:0] h;
      int j;
      h = (d < 4) ? hy : hx;
      j = d % 4;
      return (j != 0) && ((h >> (4 * j)) == 16'h0000);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      cycle++;
      if (fd_a === 1'b1) begin
         if (last_fd >= 0) check("frame_period", 32'(cycle - last_fd), 32'(8 * DIV));
         last_fd = cycle;
         fd_count++;
      end
   endtask

   task automatic reset_check(input string tag);
      check({tag, "_en"},    32'(en_a),   32'hFF);
      check({tag, "_seg"},   32'(out7_a), 32'h7F);
      check({tag, "_fd"},    32'(fd_a),   32'h0);
      check({tag, "_en_b"},  32'(en_b),   32'hFF);
      check({tag, "_seg_b"}, 32'(out7_b), 32'h7F);
      check({tag, "_fd_b"},  32'(fd_b),   32'h0);
   endtask

   task automatic push_frame(input int f, input logic [15:0] ax, input logic [15:0] ay,
                             input logic [15:0] bx, input logic [15:0] by, input int n);
      for (int i = 0; i < n; i++) begin
         slot_t e;
         e.tag   = $sformatf("f%0d_d%0d", f, i);
         e.en    = ~(8'h01 << i);
         e.seg_a = hex_ref(nib_of(ax, ay, i));
         e.seg_b = lz_ref(bx, by, i) ? 7'h7F : hex_ref(nib_of(bx, by, i));
         sb_q.push_back(e);
      end
   endtask

   // Wait for the next enabled digit, compare it, then measure its width and the dark gap after it.
   task automatic scan_slot();
      slot_t      e;
      logic [7:0] cur;
      int         n;
      e = sb_q.pop_front();
      n = 0;
      do begin
         step();
         n++;
      end while (en_a === 8'hFF && n < 2 * DIV);
      check({e.tag, "_en"},    32'(en_a),   32'(e.en));
      check({e.tag, "_seg"},   32'(out7_a), 32'(e.seg_a));
      check({e.tag, "_en_b"},  32'(en_b),   32'(e.en));
      check({e.tag, "_seg_b"}, 32'(out7_b), 32'(e.seg_b));
      cur = en_a;
      n = 1;
      step();
      while (en_a === cur && n < 2 * DIV) begin
         n++;
         step();
      end
      check({e.tag, "_width"}, 32'(n),    32'(DIV - 1));
      check({e.tag, "_ghost"}, 32'(en_a), 32'hFF);
   endtask

   task automatic scan_slots(input int n);
      for (int i = 0; i < n; i++) scan_slot();
   endtask

   initial begin
      rst = 1'b1;
      x   = 32'h1234_ABCD;
      y   = 32'h0000_0000;
      xb  = 32'h0000_0050;
      yb  = 32'h0000_0000;

      for (int i = 0; i < 3; i++) begin
         step();
         reset_check("rst_hold");
      end

      // Frame 1: snapshot is still the reset value.
      rst = 1'b0;
      x   = 32'h0000_1234;
      y   = 32'h0000_ABCD;
      push_frame(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8);
      scan_slots(8);

      // Frame 2 shows the first snapshot; upper bus bits must be ignored.
      y = 32'hFFFF_1111;
      push_frame(2, 16'h1234, 16'hABCD, 16'h0050, 16'h0000, 8);
      scan_slots(8);

      // Frame 3: y changes while digit 2 is current; the frame must not tear.
      push_frame(3, 16'h1234, 16'h1111, 16'h0050, 16'h0000, 8);
      scan_slots(2);
      y = 32'h0000_2222;
      scan_slots(6);

      push_frame(4, 16'h1234, 16'h2222, 16'h0050, 16'h0000, 8);
      scan_slots(8);

      // Frame 5 is cut short by a reset while digit 5 is current.
      push_frame(5, 16'h1234, 16'h2222, 16'h0050, 16'h0000, 5);
      scan_slots(5);
      rst = 1'b1;
      step();
      reset_check("mid_rst");
      step();
      reset_check("mid_rst_hold");
      rst     = 1'b0;
      last_fd = -1;

      push_frame(6, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8);
      scan_slots(8);

      check("frame_done_count", 32'(fd_count), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
